// File: rtl/mips_pkg.sv
// Shared MIPS core definitions: reset vector, NOP encoding, fetch states and
// the opcodes the front end cares about.
package mips_pkg;

   localparam logic [31:0] RESET_PC_DEFAULT = 32'h0040_0000;
   localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;   // sll $0,$0,0

   localparam logic [5:0] OP_J   = 6'h02;
   localparam logic [5:0] OP_JAL = 6'h03;
   localparam logic [5:0] OP_BEQ = 6'h04;
   localparam logic [5:0] OP_BNE = 6'h05;

   typedef enum logic [1:0] {
      FETCH   = 2'd0,
      HOLD    = 2'd1,
      DISCARD = 2'd2
   } fetch_state_e;

   // J/JAL target: region bits of the delay-slot PC plus the word index.
   function automatic logic [31:0] jump_target(input logic [3:0]  pc_region,
                                               input logic [25:0] index);
      return {pc_region, index, 2'b00};
   endfunction

endpackage

// File: rtl/next_pc_select.sv
// Redirect arbitration: picks the new PC when any control-flow change resolves.
module next_pc_select
   import mips_pkg::*;
(
   input  logic        branch_taken_i,
   input  logic [31:0] branch_target_i,
   input  logic        jump_i,
   input  logic [25:0] jump_index_i,
   input  logic        jr_i,
   input  logic [31:0] jr_target_i,
   input  logic [3:0]  pc_region_i,
   output logic        redirect_o,
   output logic [31:0] target_o
);

   // jr resolves with the highest priority, then the EX branch, then the J/JAL jump
   always_comb begin
      target_o = jump_target(pc_region_i, jump_index_i);
      if (jr_i) begin
         target_o = jr_target_i;
      end else if (branch_taken_i) begin
         target_o = branch_target_i;
      end
   end

   assign redirect_o = jr_i | branch_taken_i | jump_i;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage with IF/ID pipeline register.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   FETCH   | request at req_addr outstanding, waiting for imem_ack
//   HOLD    | fetched word parked in skid while ID is stalled, no request
//   DISCARD | redirected while a request was in flight; drop its response
module fetch_stage
   import mips_pkg::*;
#(
   parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
)
(
   input  logic        clk,
   input  logic        reset,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   input  logic        stall,
   input  logic        branch_taken,
   input  logic [31:0] branch_target,
   input  logic        jump,
   input  logic [25:0] jump_index,
   input  logic        jr,
   input  logic [31:0] jr_target,
   output logic        if_id_valid,
   output logic [31:0] if_id_instr,
   output logic [31:0] if_id_pc_plus4,
   output logic [5:0]  OP,
   output logic [5:0]  Function
);

   fetch_state_e state_q;
   logic [31:0]  pc_q;
   logic [31:0]  req_addr_q;
   logic [31:0]  skid_q;
   logic [31:0]  skid_pc4_q;
   logic         valid_q;
   logic [31:0]  instr_q;
   logic [31:0]  pc4_q;

   logic         redirect;
   logic [31:0]  target;
   logic [31:0]  req_plus4;

   next_pc_select u_next_pc_select (
      .branch_taken_i  (branch_taken),
      .branch_target_i (branch_target),
      .jump_i          (jump),
      .jump_index_i    (jump_index),
      .jr_i            (jr),
      .jr_target_i     (jr_target),
      .pc_region_i     (pc4_q[31:28]),
      .redirect_o      (redirect),
      .target_o        (target)
   );

   assign req_plus4 = req_addr_q + 32'd4;

   // Request is a pure function of state so it cannot drop before the ack;
   // gating with reset keeps it low for the whole reset window.
   assign imem_req  = (state_q != HOLD) && !reset;
   assign imem_addr = req_addr_q;

   // Fetch FSM, PC/request address, skid buffer and IF/ID register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= FETCH;
         pc_q       <= RESET_PC;
         req_addr_q <= RESET_PC;
         skid_q     <= 32'h0;
         skid_pc4_q <= 32'h0;
         valid_q    <= 1'b0;
         instr_q    <= NOP_INSTR;
         pc4_q      <= 32'h0;
      end else begin
         case (state_q)
            FETCH: begin
               if (redirect) begin
                  valid_q <= 1'b0;
                  instr_q <= NOP_INSTR;
                  pc_q    <= target;
                  if (imem_ack) begin
                     req_addr_q <= target;
                  end else begin
                     // request already on the bus must complete at its old address
                     state_q <= DISCARD;
                  end
               end else if (imem_ack) begin
                  pc_q <= req_plus4;
                  if (stall) begin
                     skid_q     <= imem_rdata;
                     skid_pc4_q <= req_plus4;
                     state_q    <= HOLD;
                  end else begin
                     valid_q    <= 1'b1;
                     instr_q    <= imem_rdata;
                     pc4_q      <= req_plus4;
                     req_addr_q <= req_plus4;
                  end
               end else if (!stall) begin
                  valid_q <= 1'b0;
                  instr_q <= NOP_INSTR;
               end
            end

            DISCARD: begin
               if (redirect) begin
                  pc_q <= target;
               end
               if (imem_ack) begin
                  req_addr_q <= redirect ? target : pc_q;
                  state_q    <= FETCH;
               end
               if (redirect || !stall) begin
                  valid_q <= 1'b0;
                  instr_q <= NOP_INSTR;
               end
            end

            HOLD: begin
               if (redirect) begin
                  pc_q       <= target;
                  req_addr_q <= target;
                  valid_q    <= 1'b0;
                  instr_q    <= NOP_INSTR;
                  state_q    <= FETCH;
               end else if (!stall) begin
                  valid_q    <= 1'b1;
                  instr_q    <= skid_q;
                  pc4_q      <= skid_pc4_q;
                  req_addr_q <= pc_q;
                  state_q    <= FETCH;
               end
            end

            default: begin
               state_q <= FETCH;
            end
         endcase
      end
   end

   assign if_id_valid    = valid_q;
   assign if_id_instr    = instr_q;
   assign if_id_pc_plus4 = pc4_q;
   assign OP             = instr_q[31:26];
   assign Function       = instr_q[5:0];

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: memory model with programmable wait states that
// returns the address as data, plus a reference model and scoreboard.
module tb_fetch_stage;
   import mips_pkg::*;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack = 1'b0;
   logic [31:0] imem_rdata = 32'h0;
   logic        stall = 1'b0;
   logic        branch_taken = 1'b0;
   logic [31:0] branch_target = 32'h0;
   logic        jump = 1'b0;
   logic [25:0] jump_index = 26'h0;
   logic        jr = 1'b0;
   logic [31:0] jr_target = 32'h0;
   logic        if_id_valid;
   logic [31:0] if_id_instr;
   logic [31:0] if_id_pc_plus4;
   logic [5:0]  OP;
   logic [5:0]  Function;

   always #5 clk = ~clk;

   fetch_stage #(.RESET_PC(32'h0040_0000)) dut (
      .clk            (clk),
      .reset          (reset),
      .imem_req       (imem_req),
      .imem_addr      (imem_addr),
      .imem_ack       (imem_ack),
      .imem_rdata     (imem_rdata),
      .stall          (stall),
      .branch_taken   (branch_taken),
      .branch_target  (branch_target),
      .jump           (jump),
      .jump_index     (jump_index),
      .jr             (jr),
      .jr_target      (jr_target),
      .if_id_valid    (if_id_valid),
      .if_id_instr    (if_id_instr),
      .if_id_pc_plus4 (if_id_pc_plus4),
      .OP             (OP),
      .Function       (Function)
   );

   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] pc4;
   } sb_item_t;

   sb_item_t    sbq[$];
   int          n_checks = 0;
   int          n_fail = 0;
   int          wait_cycles = 0;
   int          wait_cnt = 0;
   logic        last_acked = 1'b0;
   logic        m_valid, m_hold, m_discard;
   logic [31:0] m_instr, m_pc4, exp_fetch;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: observed %h expected %h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      sbq.delete();
      m_valid   = 1'b0;
      m_hold    = 1'b0;
      m_discard = 1'b0;
      m_instr   = 32'h0;
      m_pc4     = 32'h0;
      exp_fetch = 32'h0040_0000;
      wait_cnt  = 0;
   endtask

   task automatic sb_load();
      sb_item_t it;
      check_val("sb_depth", 32'(sbq.size()), 32'd1);
      if (sbq.size() != 0) begin
         it      = sbq.pop_front();
         m_valid = 1'b1;
         m_instr = it.instr;
         m_pc4   = it.pc4;
      end
   endtask

   task automatic sb_drop();
      sb_item_t it;
      check_val("sb_depth", 32'(sbq.size()), 32'd1);
      if (sbq.size() != 0) it = sbq.pop_front();
   endtask

   task automatic flush_model();
      m_valid = 1'b0;
      m_instr = 32'h0;
   endtask

   // One clock: memory answers, model steps on pre-edge values, outputs checked after the edge.
   task automatic cycle();
      logic        pre_req, acked, redir;
      logic [31:0] pre_addr, tgt;
      imem_ack   = imem_req && (wait_cnt >= wait_cycles);
      imem_rdata = imem_addr;
      pre_req    = imem_req;
      pre_addr   = imem_addr;
      acked      = imem_ack;
      redir      = jr | branch_taken | jump;
      tgt        = jr ? jr_target :
                   branch_taken ? branch_target : {m_pc4[31:28], jump_index, 2'b00};
      check_val("imem_req", 32'(imem_req), 32'(!m_hold));
      if (!m_hold && !m_discard) check_val("imem_addr", imem_addr, exp_fetch);

      if (m_hold) begin
         if (redir) begin
            sb_drop();
            m_hold    = 1'b0;
            exp_fetch = tgt;
            flush_model();
         end else if (!stall) begin
            sb_load();
            m_hold = 1'b0;
         end
      end else if (acked) begin
         if (m_discard) begin
            m_discard = 1'b0;
            if (redir) exp_fetch = tgt;
            if (redir || !stall) flush_model();
         end else if (redir) begin
            exp_fetch = tgt;
            flush_model();
         end else begin
            sbq.push_back({pre_addr, exp_fetch + 32'd4});
            exp_fetch = exp_fetch + 32'd4;
            if (stall) m_hold = 1'b1;
            else sb_load();
         end
      end else begin
         if (redir) begin
            exp_fetch = tgt;
            m_discard = 1'b1;
            flush_model();
         end else if (!stall) begin
            flush_model();
         end
      end

      @(posedge clk);
      #1;
      last_acked = acked;
      if (acked) wait_cnt = 0;
      else if (pre_req) wait_cnt++;

      check_val("if_id_valid", 32'(if_id_valid), 32'(m_valid));
      check_val("if_id_instr", if_id_instr, m_instr);
      check_val("if_id_pc_plus4", if_id_pc_plus4, m_pc4);
      check_val("OP", 32'(OP), 32'(m_instr[31:26]));
      check_val("Function", 32'(Function), 32'(m_instr[5:0]));
   endtask

   task automatic check_reset_outputs(input string tag);
      check_val({tag, "_req"}, 32'(imem_req), 32'd0);
      check_val({tag, "_valid"}, 32'(if_id_valid), 32'd0);
      check_val({tag, "_instr"}, if_id_instr, 32'h0);
      check_val({tag, "_pc4"}, if_id_pc_plus4, 32'h0);
      check_val({tag, "_op"}, 32'(OP), 32'd0);
      check_val({tag, "_fn"}, 32'(Function), 32'd0);
   endtask

   initial begin
      // reset and first fetches with zero-wait memory
      repeat (2) @(posedge clk);
      #1;
      check_reset_outputs("rst");
      check_val("rst_addr", imem_addr, 32'h0040_0000);
      reset = 1'b0;
      model_reset();
      #1;
      check_val("req_after_release", 32'(imem_req), 32'd1);
      cycle();
      check_val("first_pc4", if_id_pc_plus4, 32'h0040_0004);
      check_val("first_instr", if_id_instr, 32'h0040_0000);
      check_val("second_addr", imem_addr, 32'h0040_0004);
      repeat (3) cycle();

      // two wait states per access
      wait_cycles = 2;
      repeat (10) cycle();

      // stall on an ack edge for three cycles, then release
      wait_cycles = 0;
      cycle();
      stall = 1'b1;
      repeat (3) cycle();
      check_val("hold_req", 32'(imem_req), 32'd0);
      stall = 1'b0;
      repeat (4) cycle();

      // branch while a request is outstanding
      wait_cycles = 2;
      for (int i = 0; i < 10 && !last_acked; i++) cycle();
      if (!last_acked) cycle();
      check_val("br_setup_acked", 32'(last_acked), 32'd1);
      branch_taken  = 1'b1;
      branch_target = 32'h0040_0100;
      cycle();
      branch_taken = 1'b0;
      check_val("br_flush_valid", 32'(if_id_valid), 32'd0);
      check_val("br_flush_instr", if_id_instr, 32'h0);
      for (int i = 0; i < 10 && m_discard; i++) cycle();
      check_val("br_discard_done", 32'(m_discard), 32'd0);
      check_val("br_target_req", imem_addr, 32'h0040_0100);
      repeat (6) cycle();

      // all three redirects at once: jr wins
      wait_cycles = 0;
      cycle();
      jr            = 1'b1;
      jr_target     = 32'h0040_0200;
      branch_taken  = 1'b1;
      branch_target = 32'h0040_0300;
      jump          = 1'b1;
      jump_index    = 26'h0000_123;
      cycle();
      jr = 1'b0; branch_taken = 1'b0; jump = 1'b0;
      check_val("prio_req", imem_addr, 32'h0040_0200);
      repeat (2) cycle();

      // jump alone from pc_plus4 0x00400010
      jr        = 1'b1;
      jr_target = 32'h0040_000C;
      cycle();
      jr = 1'b0;
      cycle();
      check_val("jmp_pc4", if_id_pc_plus4, 32'h0040_0010);
      jump       = 1'b1;
      jump_index = 26'h000_0040;
      cycle();
      jump = 1'b0;
      check_val("jmp_req", imem_addr, 32'h0000_0100);
      repeat (3) cycle();

      // reset in the middle of HOLD
      stall = 1'b1;
      repeat (2) cycle();
      check_val("pre_rst_hold_req", 32'(imem_req), 32'd0);
      #2;
      reset = 1'b1;
      #1;
      check_reset_outputs("midrst");
      stall = 1'b0;
      @(posedge clk);
      #1;
      check_reset_outputs("midrst_held");
      reset = 1'b0;
      model_reset();
      #1;
      check_val("restart_req", 32'(imem_req), 32'd1);
      check_val("restart_addr", imem_addr, 32'h0040_0000);
      repeat (4) cycle();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
